// File: rtl/we_seq_pkg.sv
// rtl/we_seq_pkg.sv - shared widths and state encodings for the WETOP task sequencer
package we_seq_pkg;

  localparam int RUN_W_DEF   = 16;
  localparam int TIME_W_DEF  = 32;
  localparam int SEQ_STATE_W = 3;

  // State encodings are exported on seq_state, so their values are fixed
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CFG       = 3'd1;
  localparam logic [2:0] S_WAIT_SPI  = 3'd2;
  localparam logic [2:0] S_TASK      = 3'd3;
  localparam logic [2:0] S_WAIT_TASK = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;
  localparam logic [2:0] S_HOLD      = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

endpackage

// File: rtl/we_seq_timer.sv
// rtl/we_seq_timer.sv - clearable up-counter with terminal-compare flag
module we_seq_timer
  import we_seq_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [TIME_W-1:0] term_i,
  output logic              hit_o
);

  logic [TIME_W-1:0] cnt_q;
  logic [TIME_W-1:0] cnt_d;

  // Clear wins over count; the counter wraps silently (callers bound it)
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TIME_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/we_task_sequencer.sv
// rtl/we_task_sequencer.sv - multi-run config/task scheduler for WETOP; WE_SEQ_TIMEOUT_EN adds wait timeouts
module we_task_sequencer
  import we_seq_pkg::*;
#(
  parameter int RUN_W  = RUN_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic                   clk_512k,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [RUN_W-1:0]       n_runs,
  input  logic [TIME_W-1:0]      t_gap,
  input  logic                   cfg_once,
  input  logic                   done_spi,
  input  logic                   done_task,
  input  logic                   full_ppfifo,
`ifdef WE_SEQ_TIMEOUT_EN
  input  logic [TIME_W-1:0]      t_timeout,
  output logic                   err_timeout,
`endif
  output logic                   trigger_config,
  output logic                   trigger_task,
  output logic                   busy,
  output logic                   seq_done,
  output logic [RUN_W-1:0]       run_idx,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [RUN_W-1:0]  run_idx_q;
  logic [RUN_W-1:0]  run_idx_d;
  logic              seq_done_q;
  logic              seq_done_d;
  logic [RUN_W-1:0]  n_runs_q;
  logic [TIME_W-1:0] t_gap_q;
  logic              cfg_once_q;
  logic              spi_prev_q;
  logic              task_prev_q;
  logic              spi_rise;
  logic              task_rise;
  logic              accept;
  logic              tmo_hit;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_hit;
  logic [TIME_W-1:0] tmr_term;

  assign spi_rise  = done_spi  & ~spi_prev_q;
  assign task_rise = done_task & ~task_prev_q;

  // Previous-cycle levels of the WETOP done flags for rising-edge detection
  always_ff @(posedge clk_512k) begin
    if (rst) begin
      spi_prev_q  <= 1'b0;
      task_prev_q <= 1'b0;
    end else begin
      spi_prev_q  <= done_spi;
      task_prev_q <= done_task;
    end
  end

  // Sequencing decisions; abort overrides everything computed for this cycle
  always_comb begin
    state_d    = state_q;
    run_idx_d  = run_idx_q;
    seq_done_d = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          run_idx_d = '0;
          if (n_runs == '0) begin
            seq_done_d = 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!full_ppfifo) begin
          state_d = ((run_idx_q == '0) || !cfg_once_q) ? S_CFG : S_TASK;
        end
      end
      S_CFG: state_d = S_WAIT_SPI;
      S_WAIT_SPI: begin
        if (spi_rise) begin
          state_d = S_TASK;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_TASK: state_d = S_WAIT_TASK;
      S_WAIT_TASK: begin
        if (task_rise) begin
          if (run_idx_q == n_runs_q - RUN_W'(1)) begin
            seq_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            run_idx_d = run_idx_q + RUN_W'(1);
            state_d   = (t_gap_q == '0) ? S_HOLD : S_GAP;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        if (tmr_hit) begin
          state_d = S_HOLD;
        end
      end
`ifdef WE_SEQ_TIMEOUT_EN
      S_ERR: state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      run_idx_d  = run_idx_q;
      seq_done_d = 1'b0;
      accept     = 1'b0;
    end
  end

  // State, run index and completion pulse
  always_ff @(posedge clk_512k) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_idx_q  <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_idx_q  <= run_idx_d;
      seq_done_q <= seq_done_d;
    end
  end

  // Settings are captured only when a start is accepted
  always_ff @(posedge clk_512k) begin
    if (rst) begin
      n_runs_q   <= '0;
      t_gap_q    <= '0;
      cfg_once_q <= 1'b0;
    end else if (accept) begin
      n_runs_q   <= n_runs;
      t_gap_q    <= t_gap;
      cfg_once_q <= cfg_once;
    end
  end

  // One timer serves GAP and both waits; it restarts on every state change
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == S_GAP) || (state_q == S_WAIT_SPI) || (state_q == S_WAIT_TASK);

`ifdef WE_SEQ_TIMEOUT_EN
  logic [TIME_W-1:0] t_timeout_q;
  logic              err_q;

  assign tmr_term = (state_q == S_GAP) ? (t_gap_q - TIME_W'(1)) : (t_timeout_q - TIME_W'(1));
  assign tmo_hit  = (t_timeout_q != '0) && tmr_hit && (state_q != S_GAP);

  // Timeout limit latched with the settings; sticky error cleared by the next accepted start
  always_ff @(posedge clk_512k) begin
    if (rst) begin
      t_timeout_q <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      t_timeout_q <= t_timeout;
      err_q       <= 1'b0;
    end else if ((state_d == S_ERR) && (state_q != S_ERR)) begin
      err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmr_term = t_gap_q - TIME_W'(1);
  assign tmo_hit  = 1'b0;
`endif

  we_seq_timer #(
    .TIME_W (TIME_W)
  ) u_timer (
    .clk_i  (clk_512k),
    .rst_i  (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .hit_o  (tmr_hit)
  );

  assign trigger_config = (state_q == S_CFG);
  assign trigger_task   = (state_q == S_TASK);
  assign busy           = (state_q != S_IDLE);
  assign seq_done       = seq_done_q;
  assign run_idx        = run_idx_q;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_we_task_sequencer.sv
// tb/tb_we_task_sequencer.sv - randomized self-checking bench for we_task_sequencer
module tb_we_task_sequencer;
  import we_seq_pkg::*;

  localparam int RUN_W  = 16;
  localparam int TIME_W = 32;
  localparam int MAXC   = 2048;
  localparam int NONE   = 1000000;

  logic              clk_512k = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [RUN_W-1:0]  n_runs;
  logic [TIME_W-1:0] t_gap;
  logic              cfg_once;
  logic              done_spi;
  logic              done_task;
  logic              full_ppfifo;
`ifdef WE_SEQ_TIMEOUT_EN
  logic [TIME_W-1:0] t_timeout;
  logic              err_timeout;
`endif
  logic              trigger_config;
  logic              trigger_task;
  logic              busy;
  logic              seq_done;
  logic [RUN_W-1:0]  run_idx;
  logic [2:0]        seq_state;

  we_task_sequencer #(
    .RUN_W  (RUN_W),
    .TIME_W (TIME_W)
  ) dut (
    .clk_512k       (clk_512k),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .n_runs         (n_runs),
    .t_gap          (t_gap),
    .cfg_once       (cfg_once),
    .done_spi       (done_spi),
    .done_task      (done_task),
    .full_ppfifo    (full_ppfifo),
`ifdef WE_SEQ_TIMEOUT_EN
    .t_timeout      (t_timeout),
    .err_timeout    (err_timeout),
`endif
    .trigger_config (trigger_config),
    .trigger_task   (trigger_task),
    .busy           (busy),
    .seq_done       (seq_done),
    .run_idx        (run_idx),
    .seq_state      (seq_state)
  );

  always #5 clk_512k = ~clk_512k;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Relative-cycle bookkeeping: cycle 0 is the cycle in which start is driven
  bit full_sched [MAXC];
  int cyc, spi_at, task_at, dspi, dtask, busy_cnt;
  int n_task_seen, n_done_seen, last_task_cyc;
  bit scramble;
  int act_q[$];
  int exp_q[$];

  // Event code: kind 1=trigger_config 2=trigger_task 3=seq_done, with cycle and run index
  function automatic int ev(input int kind, input int c, input int idx);
    return kind * 10000000 + c * 1000 + idx;
  endfunction

  // Advance one cycle: drive inputs (WETOP model, FIFO schedule), sample outputs at negedge
  task automatic cycle(input bit st, input bit ab);
    @(posedge clk_512k);
    #1;
    start       = st;
    abort       = ab;
    done_spi    = (cyc >= spi_at)  && (cyc < spi_at + 2);
    done_task   = (cyc >= task_at) && (cyc < task_at + 2);
    full_ppfifo = (cyc < MAXC) ? full_sched[cyc] : 1'b0;
    if (scramble && !st) begin
      n_runs   = RUN_W'($urandom_range(0, 7));
      t_gap    = TIME_W'($urandom_range(0, 9));
      cfg_once = 1'($urandom_range(0, 1));
    end
    @(negedge clk_512k);
    if (busy === 1'b1) busy_cnt++;
    if (trigger_config === 1'b1) begin
      act_q.push_back(ev(1, cyc, int'(run_idx)));
      spi_at = cyc + dspi;
    end
    if (trigger_task === 1'b1) begin
      act_q.push_back(ev(2, cyc, int'(run_idx)));
      task_at = cyc + dtask;
      n_task_seen++;
      last_task_cyc = cyc;
    end
    if (seq_done === 1'b1) begin
      act_q.push_back(ev(3, cyc, int'(run_idx)));
      n_done_seen++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk_512k);
    #1;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    done_spi = 1'b0; done_task = 1'b0; full_ppfifo = 1'b0;
    @(posedge clk_512k);
    #1;
    rst = 1'b0;
  endtask

  task automatic make_full(input int nwin, input int maxlen);
    foreach (full_sched[i]) full_sched[i] = 1'b0;
    for (int w = 0; w < nwin; w++) begin
      int s;
      int l;
      s = $urandom_range(1, 150);
      l = $urandom_range(1, maxlen);
      for (int i = s; i < s + l && i < MAXC; i++) full_sched[i] = 1'b1;
    end
  endtask

  task automatic setup(input int n, input int gap, input bit once, input int ds, input int dt);
    n_runs = RUN_W'(n); t_gap = TIME_W'(gap); cfg_once = once;
    dspi = ds; dtask = dt;
    cyc = 0; spi_at = NONE; task_at = NONE; busy_cnt = 0;
    n_task_seen = 0; n_done_seen = 0; last_task_cyc = -1;
    act_q.delete(); exp_q.delete();
  endtask

  // Timeline model: run r leaves HOLD at the first non-full cycle; returns the seq_done cycle
  function automatic int build_expected(input int n, input int gap, input bit once);
    int h, t, d;
    if (n == 0) begin
      exp_q.push_back(ev(3, 1, 0));
      return 1;
    end
    h = 1;
    for (int r = 0; r < n; r++) begin
      while (h < MAXC - 1 && full_sched[h]) h++;
      if (r == 0 || !once) begin
        exp_q.push_back(ev(1, h + 1, r));
        t = h + 2 + dspi;
      end else begin
        t = h + 1;
      end
      exp_q.push_back(ev(2, t, r));
      d = t + dtask;
      if (r == n - 1) begin
        exp_q.push_back(ev(3, d + 1, r));
        return d + 1;
      end
      h = d + 1 + gap;
    end
    return 0;
  endfunction

  task automatic run_case(input string nm, input int n, input int gap, input bit once,
                          input int ds, input int dt);
    int sd;
    do_reset();
    setup(n, gap, once, ds, dt);
    sd = build_expected(n, gap, once);
    cycle(1'b1, 1'b0);
    while (cyc < sd + 6) cycle(1'b0, 1'b0);
    check_val({nm, "_nev"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_val($sformatf("%s_ev%0d", nm, i), (i < act_q.size()) ? act_q[i] : -1, exp_q[i]);
    check_val({nm, "_busy_cycles"}, busy_cnt, sd - 1);
    check_val({nm, "_run_idx_hold"}, run_idx, (n == 0) ? 0 : n - 1);
    check_val({nm, "_end_state"}, seq_state, S_IDLE);
  endtask

  task automatic run_abort();
    int a, guard;
    do_reset();
    make_full(0, 1);
    setup(3, 2, 1'b0, 3, 6);
    cycle(1'b1, 1'b0);
    guard = 0;
    while (n_task_seen < 2 && guard < 500) begin cycle(1'b0, 1'b0); guard++; end
    check_val("ab_reach_run1_task", n_task_seen, 2);
    a = last_task_cyc + dtask;
    while (cyc < a && guard < 1000) begin cycle(1'b0, 1'b0); guard++; end
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    check_val("ab_state_idle", seq_state, S_IDLE);
    check_val("ab_busy", busy, 0);
    check_val("ab_run_idx_held", run_idx, 1);
    check_val("ab_no_seq_done", n_done_seen, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("ab_restart_cfg", trigger_config, 1);
    check_val("ab_restart_idx", run_idx, 0);
    do_reset();
    @(negedge clk_512k);
    check_val("midrun_rst_state", seq_state, S_IDLE);
    check_val("midrun_rst_busy", busy, 0);
  endtask

`ifdef WE_SEQ_TIMEOUT_EN
  task automatic run_timeout();
    do_reset();
    make_full(0, 1);
    setup(1, 0, 1'b0, NONE, 5);
    t_timeout = 10;
    cycle(1'b1, 1'b0);
    while (cyc < 13) cycle(1'b0, 1'b0);
    check_val("to_still_waiting", seq_state, S_WAIT_SPI);
    cycle(1'b0, 1'b0);
    check_val("to_err_state", seq_state, S_ERR);
    check_val("to_err_flag", err_timeout, 1);
    check_val("to_busy", busy, 1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check_val("to_abort_idle", seq_state, S_IDLE);
    check_val("to_flag_sticky", err_timeout, 1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check_val("to_flag_cleared", err_timeout, 0);
    t_timeout = 0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_once = 1'b0;
    done_spi = 1'b0; done_task = 1'b0; full_ppfifo = 1'b0;
    n_runs = '0; t_gap = '0; scramble = 1'b0;
`ifdef WE_SEQ_TIMEOUT_EN
    t_timeout = '0;
`endif
    repeat (2) @(posedge clk_512k);
    @(negedge clk_512k);
    check_val("rst_trigger_config", trigger_config, 0);
    check_val("rst_trigger_task", trigger_task, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_seq_done", seq_done, 0);
    check_val("rst_run_idx", run_idx, 0);
    check_val("rst_state", seq_state, S_IDLE);

    make_full(0, 1);
    run_case("basic3", 3, 4, 1'b0, 5, 20);
    run_case("cfgonce4", 4, 4, 1'b1, 5, 20);
    run_case("zero_runs", 0, 4, 1'b0, 5, 20);
    foreach (full_sched[i]) full_sched[i] = (i >= 25 && i < 75);
    run_case("fifo_hold", 3, 4, 1'b0, 5, 20);
    make_full(0, 1);
    run_case("gap0", 2, 0, 1'b1, 1, 1);
    run_abort();
`ifdef WE_SEQ_TIMEOUT_EN
    run_timeout();
`endif

    scramble = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int n, g, ds, dt;
      bit once;
      n    = $urandom_range(0, 4);
      g    = $urandom_range(0, 5);
      once = 1'($urandom_range(0, 1));
      ds   = $urandom_range(1, 6);
      dt   = $urandom_range(1, 10);
      make_full($urandom_range(0, 2), 30);
      run_case($sformatf("rnd%0d", k), n, g, once, ds, dt);
    end
    scramble = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
